// File: rtl/ula_op_seq.sv
// ula_op_seq: registered operation sequencer placed in front of ula_8_bits.
// Accepts 8- or 16-bit commands over valid/ready and drives the ALU operand,
// select, mode and carry-in inputs from registers. A 16-bit command takes two
// ALU passes, low byte then high byte, with the carry chained between them.
// The assembled result and flags are held on a valid/ready result port.
module ula_op_seq #(
   parameter bit WIDE_EN = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   // command port
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_s,
   input  logic             cmd_m,
   input  logic             cmd_cin,
   input  logic             cmd_wide,
   input  logic [15:0]      cmd_a,
   input  logic [15:0]      cmd_b,
   // ALU drive
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_s,
   output logic             alu_m,
   output logic             alu_cin,
   // ALU response
   input  logic [7:0]       alu_f,
   input  logic             alu_c_out,
   input  logic             alu_overflow,
   input  logic             alu_a_eq_b,
   // result port
   output logic             res_valid,
   input  logic             res_ready,
   output logic [15:0]      res_f,
   output logic             res_c_out,
   output logic             res_overflow,
   output logic             res_eq,
   output logic             res_zero,
   output logic [CNT_W-1:0] res_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   // Arithmetic functions for which the ALU reports carry in borrow polarity.
   function automatic logic is_borrow_fn(input logic [3:0] s);
      case (s)
         4'b0000, 4'b0010, 4'b0011,
         4'b0110, 4'b0111, 4'b1011: is_borrow_fn = 1'b1;
         default:                   is_borrow_fn = 1'b0;
      endcase
   endfunction

   // Carry into the high pass: the raw byte carry of the low pass. In logic
   // mode the ALU ignores carry, so the command carry-in is simply reused.
   function automatic logic hcin_sel(input logic       m,
                                     input logic [3:0] s,
                                     input logic       c_out,
                                     input logic       cmd_carry);
      if (m)
         hcin_sel = cmd_carry;
      else if (is_borrow_fn(s))
         hcin_sel = ~c_out;
      else
         hcin_sel = c_out;
   endfunction

   // Carry and overflow carry no meaning in logic mode and are reported as 0.
   function automatic logic arith_flag(input logic m, input logic flag);
      arith_flag = flag & ~m;
   endfunction

   state_t           state_q;
   logic             cmd_ready_q;
   logic             res_valid_q;
   logic [7:0]       alu_a_q;
   logic [7:0]       alu_b_q;
   logic [3:0]       alu_s_q;
   logic             alu_m_q;
   logic             alu_cin_q;
   logic             wide_q;
   logic             cin_q;
   logic [7:0]       a_hi_q;
   logic [7:0]       b_hi_q;
   logic [7:0]       lo_f_q;
   logic             eq_lo_q;
   logic [15:0]      res_f_q;
   logic             res_c_q;
   logic             res_ovf_q;
   logic             res_eq_q;
   logic             res_zero_q;
   logic [CNT_W-1:0] res_count_q;

   logic             wide_d;
   logic             hcin_d;
   logic [15:0]      wide_f_d;

   // Derived next-state values used by the sequencer.
   always_comb begin
      wide_d   = WIDE_EN & cmd_wide;
      hcin_d   = hcin_sel(alu_m_q, alu_s_q, alu_c_out, cin_q);
      wide_f_d = {alu_f, lo_f_q};
   end

   // Sequencer FSM: command capture, ALU pass sequencing and result hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_s_q     <= '0;
         alu_m_q     <= 1'b0;
         alu_cin_q   <= 1'b0;
         wide_q      <= 1'b0;
         cin_q       <= 1'b0;
         a_hi_q      <= '0;
         b_hi_q      <= '0;
         lo_f_q      <= '0;
         eq_lo_q     <= 1'b0;
         res_f_q     <= '0;
         res_c_q     <= 1'b0;
         res_ovf_q   <= 1'b0;
         res_eq_q    <= 1'b0;
         res_zero_q  <= 1'b0;
         res_count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  alu_a_q     <= cmd_a[7:0];
                  alu_b_q     <= cmd_b[7:0];
                  alu_s_q     <= cmd_s;
                  alu_m_q     <= cmd_m;
                  alu_cin_q   <= cmd_cin;
                  wide_q      <= wide_d;
                  cin_q       <= cmd_cin;
                  a_hi_q      <= cmd_a[15:8];
                  b_hi_q      <= cmd_b[15:8];
                  cmd_ready_q <= 1'b0;
                  state_q     <= LO;
               end
            end
            LO: begin
               lo_f_q  <= alu_f;
               eq_lo_q <= alu_a_eq_b;
               if (wide_q) begin
                  alu_a_q   <= a_hi_q;
                  alu_b_q   <= b_hi_q;
                  alu_cin_q <= hcin_d;
                  state_q   <= HI;
               end else begin
                  res_f_q     <= {8'h00, alu_f};
                  res_c_q     <= arith_flag(alu_m_q, alu_c_out);
                  res_ovf_q   <= arith_flag(alu_m_q, alu_overflow);
                  res_eq_q    <= alu_a_eq_b;
                  res_zero_q  <= (alu_f == 8'h00);
                  res_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            HI: begin
               res_f_q     <= wide_f_d;
               res_c_q     <= arith_flag(alu_m_q, alu_c_out);
               res_ovf_q   <= arith_flag(alu_m_q, alu_overflow);
               res_eq_q    <= eq_lo_q & alu_a_eq_b;
               res_zero_q  <= (wide_f_d == 16'h0000);
               res_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  res_count_q <= res_count_q + CNT_W'(1);
                  state_q     <= IDLE;
               end
            end
            default: begin
               res_valid_q <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign res_valid    = res_valid_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_s        = alu_s_q;
   assign alu_m        = alu_m_q;
   assign alu_cin      = alu_cin_q;
   assign res_f        = res_f_q;
   assign res_c_out    = res_c_q;
   assign res_overflow = res_ovf_q;
   assign res_eq       = res_eq_q;
   assign res_zero     = res_zero_q;
   assign res_count    = res_count_q;

endmodule

// File: tb/tb_ula_op_seq.sv
// Testbench for ula_op_seq: a behavioural byte ALU stands in for ula_8_bits,
// a 16-bit reference model fills a scoreboard queue at command time, and
// results are popped and checked when the sequencer presents them.
module tb_ula_op_seq;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_s;
   logic             cmd_m;
   logic             cmd_cin;
   logic             cmd_wide;
   logic [15:0]      cmd_a;
   logic [15:0]      cmd_b;
   logic [7:0]       alu_a;
   logic [7:0]       alu_b;
   logic [3:0]       alu_s;
   logic             alu_m;
   logic             alu_cin;
   logic [7:0]       alu_f;
   logic             alu_c_out;
   logic             alu_overflow;
   logic             alu_a_eq_b;
   logic             res_valid;
   logic             res_ready;
   logic [15:0]      res_f;
   logic             res_c_out;
   logic             res_overflow;
   logic             res_eq;
   logic             res_zero;
   logic [CNT_W-1:0] res_count;

   int vectors = 0;
   int errs    = 0;

   typedef struct packed {
      logic [15:0] f;
      logic        c;
      logic        o;
      logic        eq;
      logic        z;
      logic        wide;
   } exp_t;

   exp_t sbq[$];

   ula_op_seq #(.WIDE_EN(1'b1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_s(cmd_s), .cmd_m(cmd_m),
      .cmd_cin(cmd_cin), .cmd_wide(cmd_wide), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
      .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_overflow(alu_overflow),
      .alu_a_eq_b(alu_a_eq_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f),
      .res_c_out(res_c_out), .res_overflow(res_overflow), .res_eq(res_eq),
      .res_zero(res_zero), .res_count(res_count)
   );

   always #5 clk = ~clk;

   function automatic logic inv_carry(input logic [3:0] s);
      return (s == 4'b0000) || (s == 4'b0010) || (s == 4'b0011) ||
             (s == 4'b0110) || (s == 4'b0111) || (s == 4'b1011);
   endfunction

   // Byte ALU stand-in: add (1001), A+~B (0110), A (0000); logic XOR/AND/NOT.
   // Logic mode drives junk carry/overflow so their masking is visible.
   logic [7:0] m_bop;
   logic [8:0] m_raw;
   always_comb begin
      m_bop        = 8'h00;
      m_raw        = 9'h000;
      alu_f        = 8'h00;
      alu_c_out    = 1'b0;
      alu_overflow = 1'b0;
      alu_a_eq_b   = (alu_a == alu_b);
      if (alu_m) begin
         case (alu_s)
            4'b0110: alu_f = alu_a ^ alu_b;
            4'b1011: alu_f = alu_a & alu_b;
            default: alu_f = ~alu_a;
         endcase
         alu_c_out    = 1'b1;
         alu_overflow = 1'b1;
      end else begin
         case (alu_s)
            4'b1001: m_bop = alu_b;
            4'b0110: m_bop = ~alu_b;
            default: m_bop = 8'h00;
         endcase
         m_raw        = {1'b0, alu_a} + {1'b0, m_bop} + {8'h00, alu_cin};
         alu_f        = m_raw[7:0];
         alu_c_out    = inv_carry(alu_s) ? ~m_raw[8] : m_raw[8];
         alu_overflow = (alu_a[7] == m_bop[7]) && (m_raw[7] != alu_a[7]);
      end
   end

   // Full-width reference, computed in one step over 8 or 16 bits.
   function automatic exp_t ref_calc(input logic m, input logic [3:0] s, input logic cin,
                                     input logic wide, input logic [15:0] a,
                                     input logic [15:0] b);
      exp_t        r;
      logic [15:0] msk, am, bm, bop, f;
      logic [16:0] raw;
      int          w;
      w   = wide ? 16 : 8;
      msk = wide ? 16'hFFFF : 16'h00FF;
      am  = a & msk;
      bm  = b & msk;
      r   = '0;
      bop = '0;
      if (m) begin
         case (s)
            4'b0110: f = am ^ bm;
            4'b1011: f = am & bm;
            default: f = ~am & msk;
         endcase
      end else begin
         if (s == 4'b1001)      bop = bm;
         else if (s == 4'b0110) bop = ~bm & msk;
         raw  = {1'b0, am} + {1'b0, bop} + {16'h0000, cin};
         f    = raw[15:0] & msk;
         r.c  = inv_carry(s) ? ~raw[w] : raw[w];
         r.o  = (am[w-1] == bop[w-1]) && (f[w-1] != am[w-1]);
      end
      r.f    = f;
      r.eq   = (am == bm);
      r.z    = (f == 16'h0000);
      r.wide = wide;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one command, push its expectation, check the accept-edge ALU load.
   task automatic send(input logic m, input logic [3:0] s, input logic cin,
                       input logic wide, input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_m     = m;
      cmd_s     = s;
      cmd_cin   = cin;
      cmd_wide  = wide;
      cmd_a     = a;
      cmd_b     = b;
      sbq.push_back(ref_calc(m, s, cin, wide, a, b));
      tick();
      // Scramble inputs after accept; the sequencer must ignore them.
      cmd_valid = 1'b0;
      cmd_a     = ~a;
      cmd_b     = ~b;
      cmd_s     = ~s;
      cmd_m     = ~m;
      cmd_cin   = ~cin;
      cmd_wide  = ~wide;
      chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      chk("alu_a_lo", {24'd0, alu_a}, {24'd0, a[7:0]});
      chk("alu_b_lo", {24'd0, alu_b}, {24'd0, b[7:0]});
      chk("alu_s", {28'd0, alu_s}, {28'd0, s});
      chk("alu_m_cin", {30'd0, alu_m, alu_cin}, {30'd0, m, cin});
   endtask

   // Wait for the result, compare with the scoreboard, hold, then drain.
   task automatic collect(input int elapsed, input int hold);
      exp_t             e;
      int               n;
      logic [CNT_W-1:0] cnt0;
      e    = sbq.pop_front();
      n    = elapsed;
      cnt0 = res_count;
      while (!res_valid && n < 10) begin
         tick();
         n++;
      end
      chk("latency", n, e.wide ? 32'd2 : 32'd1);
      chk("res_f", {16'd0, res_f}, {16'd0, e.f});
      chk("res_c_out", {31'd0, res_c_out}, {31'd0, e.c});
      chk("res_overflow", {31'd0, res_overflow}, {31'd0, e.o});
      chk("res_eq", {31'd0, res_eq}, {31'd0, e.eq});
      chk("res_zero", {31'd0, res_zero}, {31'd0, e.z});
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", {31'd0, res_valid}, 32'd1);
         chk("hold_ready", {31'd0, cmd_ready}, 32'd0);
         chk("hold_f", {12'd0, res_f, res_c_out, res_overflow, res_eq, res_zero},
             {12'd0, e.f, e.c, e.o, e.eq, e.z});
         chk("hold_count", {16'd0, res_count}, {16'd0, cnt0});
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("drain_valid", {31'd0, res_valid}, 32'd0);
      chk("drain_ready", {31'd0, cmd_ready}, 32'd1);
      chk("res_count", {16'd0, res_count}, {16'd0, cnt0 + CNT_W'(1)});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_s     = 4'h0;
      cmd_m     = 1'b0;
      cmd_cin   = 1'b0;
      cmd_wide  = 1'b0;
      cmd_a     = 16'h0000;
      cmd_b     = 16'h0000;
      res_ready = 1'b0;
      tick();
      tick();
      chk("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cin, 2'b00}, 32'd0);
      chk("rst_res", {res_f, res_valid, res_c_out, res_overflow, res_eq, res_zero, 11'd0}, 32'd0);
      chk("rst_count", {16'd0, res_count}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      #2 rst = 1'b0;
      tick();

      // Narrow add
      send(1'b0, 4'b1001, 1'b0, 1'b0, 16'h0001, 16'h0002);
      collect(0, 0);
      chk("count_after_first", {16'd0, res_count}, 32'd1);
      // Narrow add with junk upper bytes, signed overflow in 8 bits
      send(1'b0, 4'b1001, 1'b0, 1'b0, 16'hAB7F, 16'hCD01);
      collect(0, 0);
      // Wide add with carry chain; high pass must see alu_cin=1
      send(1'b0, 4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001);
      tick();
      chk("hi_alu_cin", {31'd0, alu_cin}, 32'd1);
      chk("hi_alu_ab", {16'd0, alu_a, alu_b}, 32'h0000_0000);
      collect(1, 0);
      // Wide subtract with borrow
      send(1'b0, 4'b0110, 1'b1, 1'b1, 16'h0100, 16'h0001);
      tick();
      chk("hi_alu_cin_sub", {31'd0, alu_cin}, 32'd0);
      collect(1, 0);
      // Wide signed overflow
      send(1'b0, 4'b1001, 1'b0, 1'b1, 16'h7FFF, 16'h0001);
      collect(0, 0);
      // Wide logic XOR, equal operands
      send(1'b1, 4'b0110, 1'b0, 1'b1, 16'hAA55, 16'hAA55);
      collect(0, 0);
      // Narrow logic AND, equality over the low byte only
      send(1'b1, 4'b1011, 1'b1, 1'b0, 16'h1255, 16'h3455);
      collect(0, 0);
      // Wide increment through borrow-polarity function, result zero
      send(1'b0, 4'b0000, 1'b1, 1'b1, 16'hFFFF, 16'h1234);
      collect(0, 0);
      // Backpressure: hold result for 5 cycles
      send(1'b0, 4'b1001, 1'b1, 1'b1, 16'h1234, 16'h4321);
      collect(0, 5);

      // Reset during HI of a wide command aborts it
      send(1'b0, 4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h00FF);
      void'(sbq.pop_back());
      tick();
      rst = 1'b1;
      #1;
      chk("abort_alu", {alu_a, alu_b, alu_s, alu_m, alu_cin, 2'b00}, 32'd0);
      chk("abort_res", {res_f, res_valid, res_c_out, res_overflow, res_eq, res_zero, 11'd0}, 32'd0);
      chk("abort_count", {16'd0, res_count}, 32'd0);
      #2 rst = 1'b0;
      tick();
      chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("abort_valid", {31'd0, res_valid}, 32'd0);
      tick();
      chk("abort_count_held", {16'd0, res_count}, 32'd0);

      // Operation after the aborted one
      send(1'b0, 4'b0110, 1'b1, 1'b0, 16'h0005, 16'h0005);
      collect(0, 0);
      chk("count_after_abort", {16'd0, res_count}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/ula_op_seq.md
Name: ula_op_seq

Overview:
- Registered operation sequencer that sits directly upstream of ula_8_bits.
- Accepts 8- or 16-bit commands over a valid/ready handshake and drives the ALU's a/b/s/m/c_in inputs from registers.
- For 16-bit commands it runs two ALU passes (low byte, then high byte), chaining the carry between them.
- Presents the assembled result and flags on a valid/ready result port.

Parameters:
- WIDE_EN, 1, 1 enables 16-bit two-pass commands; 0 forces cmd_wide to be treated as 0.
- CNT_W, 16, width of the completed-result counter res_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_s  in  4  ALU function select.
- cmd_m  in  1  1 = logic mode, 0 = arithmetic mode.
- cmd_cin  in  1  carry-in for the low pass.
- cmd_wide  in  1  1 = 16-bit operation.
- cmd_a  in  16  operand A (bits [15:8] ignored when narrow).
- cmd_b  in  16  operand B (bits [15:8] ignored when narrow).
- alu_a, alu_b  out  8  registered ALU operands.
- alu_s  out  4  registered ALU select.
- alu_m  out  1  registered ALU mode.
- alu_cin  out  1  registered ALU carry-in.
- alu_f  in  8  ALU result.
- alu_c_out  in  1  ALU carry-out.
- alu_overflow  in  1  ALU overflow.
- alu_a_eq_b  in  1  ALU equality flag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_f  out  16  result.
- res_c_out  out  1  final carry-out.
- res_overflow  out  1  final overflow.
- res_eq  out  1  A == B over the active width.
- res_zero  out  1  res_f == 0 over the active width.
- res_count  out  CNT_W  number of completed results; wraps modulo 2^CNT_W.

Behaviour:

Reset:
- rst=1 asynchronously forces state IDLE.
- Reset values: all alu_* = 0, res_valid = 0, res_f = 0, all res flags = 0, res_count = 0.
- rst during LO, HI or DONE aborts the operation. No result is produced and res_count is not incremented.

FSM states: IDLE, LO, HI, DONE.
- cmd_ready = 1 only in IDLE. res_valid = 1 only in DONE.

IDLE:
- On cmd_valid at edge E0, register the command.
- Load alu_a = cmd_a[7:0], alu_b = cmd_b[7:0], alu_s = cmd_s, alu_m = cmd_m, alu_cin = cmd_cin. Go to LO.

LO (ALU settles combinationally during this cycle):
- At edge E1, capture alu_f into lo_f, alu_a_eq_b into eq_lo, and alu_c_out / alu_overflow.
- If wide: load alu_a/alu_b with the high bytes, keep alu_s/alu_m, set alu_cin = hcin, go to HI.
- Else: go to DONE.

hcin (carry into the high pass):
- Arithmetic mode, cmd_s in {0000, 0010, 0011, 0110, 0111, 1011}: hcin = ~alu_c_out. The ALU reports inverted (borrow) polarity for these functions; inverting recovers the raw byte carry.
- Arithmetic mode, all other cmd_s: hcin = alu_c_out.
- Logic mode: hcin = cmd_cin (value irrelevant to the result).

HI:
- At edge E2, capture the high byte and go to DONE.
- res_f = {alu_f, lo_f}.
- res_c_out = alu_c_out and res_overflow = alu_overflow, both from the high pass.
- res_eq = eq_lo & alu_a_eq_b.

DONE, narrow command:
- res_f = {8'h00, lo_f}.
- res_c_out and res_overflow come from the low pass.
- res_eq = eq_lo.

DONE, all commands:
- res_zero is computed over the active width.
- Logic mode forces res_c_out = 0 and res_overflow = 0.
- res_valid rises at E1 (narrow) or E2 (wide).
- res_f and all flags hold stable until res_valid & res_ready at an edge. At that edge: go to IDLE, increment res_count.
- Throughput is at most one command per 3 cycles (narrow) or 4 cycles (wide). There is no bypass from DONE to accepting a new command.

Input rules:
- cmd_* is sampled only at the accept edge; changes at any other time have no effect.
- alu_* changes only at the accept edge and at E1 (wide commands).

Test Plan:
1. Narrow add: m=0 s=1001 a=0x0001 b=0x0002 cin=0 -> res_valid at E1, res_f=0x0003, c_out=0, ovf=0, eq=0, zero=0, res_count=1.
2. Wide add with carry chain: s=1001 a=0x00FF b=0x0001 cin=0 -> alu_cin=1 in HI, res_f=0x0100, c_out=0, ovf=0, res_valid at E2.
3. Wide subtract with borrow: s=0110 cin=1 a=0x0100 b=0x0001 -> low pass alu_c_out=1 so hcin=0, res_f=0x00FF, c_out=0, ovf=0.
4. Wide signed overflow: s=1001 a=0x7FFF b=0x0001 cin=0 -> res_f=0x8000, ovf=1, c_out=0.
5. Logic XOR: m=1 s=0110 a=0xAA55 b=0xAA55 wide=1 -> res_f=0x0000, zero=1, eq=1, c_out=0, ovf=0.
6. Backpressure and reset:
   - Hold res_ready=0 for 5 cycles -> res_f and flags stable, cmd_ready=0.
   - Release -> IDLE, res_count increments.
   - Then assert rst during HI of a new wide command -> immediately all outputs at reset values, res_count=0, cmd_ready=1 after release.
